// File: rtl/exe_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : exe_muldiv_unit
// Description : Iterative multiply/divide unit with architectural HI/LO
//               registers for the EXE stage. Executes MULT, MULTU, DIV, DIVU,
//               MTHI and MTLO. Multiply is shift-add and divide is restoring;
//               both take WIDTH iteration cycles. Signed operations run on
//               magnitudes and are sign-corrected in the last iteration.
//               HI/LO are written only when an op retires without cancel.
// Ports       : clk, reset          clock / synchronous active-high reset
//               op_valid, op_code   request and operation select
//               op_a, op_b          rs / rt operands
//               cancel              pipeline flush of the in-flight op
//               op_ready, busy      handshake status
//               done                one-cycle result-valid pulse
//               res_hi, res_lo      pending HI/LO values (valid with done)
//               div_by_zero         with done: divide had a zero divisor
//               hi, lo              committed HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module exe_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cancel,
    output logic             op_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_opnd;      // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0] r_acc_hi;    // partial product high half / partial remainder
    logic [WIDTH-1:0] r_acc_lo;    // multiplier being shifted out / dividend->quotient
    logic [WIDTH-1:0] r_a_raw;     // op_a as latched, returned as HI on divide-by-zero
    logic             r_neg_q;     // product / quotient must be negated
    logic             r_neg_r;     // remainder must be negated (dividend was negative)
    logic             r_dbz;
    logic [WIDTH-1:0] r_res_hi;
    logic [WIDTH-1:0] r_res_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic             w_signed;
    logic             w_last;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_mul_hi;
    logic [WIDTH-1:0]   w_mul_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;

    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_diff;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;

    logic [WIDTH-1:0] w_fin_hi;
    logic [WIDTH-1:0] w_fin_lo;

    // ------------------------------------------------------------------
    // Request decode and operand magnitudes
    // ------------------------------------------------------------------
    assign w_accept = (r_state == S_IDLE) && op_valid && !cancel;
    assign w_signed = (op_code == c_OP_MULT) || (op_code == c_OP_DIV);
    assign w_a_mag  = (w_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign w_b_mag  = (w_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    assign w_last   = (r_cnt == CNT_W'(1));

    // ------------------------------------------------------------------
    // One shift-add multiply step: add multiplicand if the multiplier LSB
    // is set, then shift the whole {hi,lo} product right by one.
    // ------------------------------------------------------------------
    assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
    assign w_prod    = {w_mul_hi, w_mul_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

    // ------------------------------------------------------------------
    // One restoring divide step: bring down the next dividend bit and
    // subtract the divisor if it fits. The difference, when kept, is
    // below the divisor so WIDTH bits are enough.
    // ------------------------------------------------------------------
    assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;
    assign w_div_hi    = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
    assign w_div_lo    = {r_acc_lo[WIDTH-2:0], w_div_ge};

    // Result of the final iteration including sign correction
    always_comb begin
        w_fin_hi = '0;
        w_fin_lo = '0;
        if (r_state == S_MUL) begin
            w_fin_hi = w_prod_fix[2*WIDTH-1:WIDTH];
            w_fin_lo = w_prod_fix[WIDTH-1:0];
        end else if (r_dbz) begin
            w_fin_hi = r_a_raw;
            w_fin_lo = '1;
        end else begin
            w_fin_hi = r_neg_r ? -w_div_hi : w_div_hi;
            w_fin_lo = r_neg_q ? -w_div_lo : w_div_lo;
        end
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (op_code)
                        c_OP_MULT, c_OP_MULTU: w_next_state = S_MUL;
                        c_OP_DIV,  c_OP_DIVU:  w_next_state = S_DIV;
                        c_OP_MTHI, c_OP_MTLO:  w_next_state = S_DONE;
                        default:               w_next_state = S_IDLE;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                if (cancel) begin
                    w_next_state = S_IDLE;
                end else if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and architectural registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_opnd   <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_a_raw  <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dbz    <= 1'b0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a_raw <= op_a;
                        r_dbz   <= 1'b0;
                        r_cnt   <= '0;
                        case (op_code)
                            c_OP_MULT, c_OP_MULTU: begin
                                r_cnt    <= CNT_W'(WIDTH);
                                r_opnd   <= w_a_mag;
                                r_acc_hi <= '0;
                                r_acc_lo <= w_b_mag;
                                r_neg_q  <= w_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                                r_neg_r  <= 1'b0;
                            end
                            c_OP_DIV, c_OP_DIVU: begin
                                r_cnt    <= CNT_W'(WIDTH);
                                r_opnd   <= w_b_mag;
                                r_acc_hi <= '0;
                                r_acc_lo <= w_a_mag;
                                r_neg_q  <= w_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                                r_neg_r  <= w_signed && op_a[WIDTH-1];
                                r_dbz    <= (op_b == '0);
                            end
                            c_OP_MTHI: begin
                                r_res_hi <= op_a;
                                r_res_lo <= r_lo;
                            end
                            c_OP_MTLO: begin
                                r_res_hi <= r_hi;
                                r_res_lo <= op_a;
                            end
                            default: begin
                                r_cnt <= '0;
                            end
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (cancel) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_state == S_MUL) begin
                            r_acc_hi <= w_mul_hi;
                            r_acc_lo <= w_mul_lo;
                        end else begin
                            r_acc_hi <= w_div_hi;
                            r_acc_lo <= w_div_lo;
                        end
                        if (w_last) begin
                            r_res_hi <= w_fin_hi;
                            r_res_lo <= w_fin_lo;
                        end
                    end
                end
                S_DONE: begin
                    // done is shown even when cancelled; only the commit is dropped
                    if (!cancel) begin
                        r_hi <= r_res_hi;
                        r_lo <= r_res_lo;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign op_ready    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign div_by_zero = (r_state == S_DONE) && r_dbz;
    assign res_hi      = r_res_hi;
    assign res_lo      = r_res_lo;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_exe_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_exe_muldiv_unit
// Description : Directed self-checking bench for exe_muldiv_unit (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exe_muldiv_unit;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic             clk;
    logic             reset;
    logic             op_valid;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cancel;
    logic             op_ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;

    exe_muldiv_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_code     (op_code),
        .op_a        (op_a),
        .op_b        (op_b),
        .cancel      (cancel),
        .op_ready    (op_ready),
        .busy        (busy),
        .done        (done),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_seen <= done_seen + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble operands after accept, wait for done, capture the
    // results, then step over the commit edge. Returns in cycle lat+1.
    task automatic run_op(input string tag, input logic [2:0] code,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int exp_lat,
                          output logic [WIDTH-1:0] rh, output logic [WIDTH-1:0] rl,
                          output logic dbz);
        int n;
        op_code  = code;
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        op_a     = 32'hDEADBEEF;
        op_b     = 32'h00000001;
        n = 1;
        while (done !== 1'b1 && n < 45) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        rh  = res_hi;
        rl  = res_lo;
        dbz = div_by_zero;
        tick();
    endtask

    initial begin
        logic [WIDTH-1:0] rh, rl;
        logic             dbz;
        int               n;
        int               seen0;

        reset    = 1'b1;
        op_valid = 1'b0;
        op_code  = 3'd0;
        op_a     = '0;
        op_b     = '0;
        cancel   = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("reset op_ready", 64'(op_ready), 64'(1));
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset dbz", 64'(div_by_zero), 64'(0));
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));

        // MULT -2 * 3 = -6
        run_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3, 33, rh, rl, dbz);
        check("mult res_hi", 64'(rh), 64'h0FFFFFFFF);
        check("mult res_lo", 64'(rl), 64'h0FFFFFFFA);
        check("mult hi", 64'(hi), 64'h0FFFFFFFF);
        check("mult lo", 64'(lo), 64'h0FFFFFFFA);

        // MULTU (2^32-2)*3 = 0x2_FFFFFFFA
        run_op("multu", 3'd1, 32'hFFFFFFFE, 32'd3, 33, rh, rl, dbz);
        check("multu hi", 64'(hi), 64'h2);
        check("multu lo", 64'(lo), 64'h0FFFFFFFA);

        run_op("divu", 3'd3, 32'd100, 32'd7, 33, rh, rl, dbz);
        check("divu dbz", 64'(dbz), 64'(0));
        check("divu hi", 64'(hi), 64'd2);
        check("divu lo", 64'(lo), 64'd14);

        // -7 / 2 -> q=-3, r=-1
        run_op("div neg", 3'd2, 32'hFFFFFFF9, 32'd2, 33, rh, rl, dbz);
        check("div neg hi", 64'(hi), 64'h0FFFFFFFF);
        check("div neg lo", 64'(lo), 64'h0FFFFFFFD);

        run_op("div ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 33, rh, rl, dbz);
        check("div ovf hi", 64'(hi), 64'h0);
        check("div ovf lo", 64'(lo), 64'h080000000);

        run_op("div zero", 3'd2, 32'hFFFFFFF9, 32'd0, 33, rh, rl, dbz);
        check("div zero dbz", 64'(dbz), 64'(1));
        check("div zero hi", 64'(hi), 64'h0FFFFFFF9);
        check("div zero lo", 64'(lo), 64'h0FFFFFFFF);

        run_op("divu zero", 3'd3, 32'd5, 32'd0, 33, rh, rl, dbz);
        check("divu zero dbz", 64'(dbz), 64'(1));
        check("divu zero hi", 64'(hi), 64'd5);
        check("divu zero lo", 64'(lo), 64'h0FFFFFFFF);

        // MULTU 7*9 cancelled at cycle 10
        seen0    = done_seen;
        op_code  = 3'd1;
        op_a     = 32'd7;
        op_b     = 32'd9;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("cancel mid busy", 64'(busy), 64'(1));
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel busy", 64'(busy), 64'(0));
        check("cancel op_ready", 64'(op_ready), 64'(1));
        check("cancel hi", 64'(hi), 64'd5);
        check("cancel lo", 64'(lo), 64'h0FFFFFFFF);

        run_op("mtlo", 3'd5, 32'h55, 32'd0, 1, rh, rl, dbz);
        check("mtlo res_hi", 64'(rh), 64'd5);
        check("cancel no done", 64'(done_seen - seen0), 64'(1));
        check("mtlo lo", 64'(lo), 64'h55);
        check("mtlo hi", 64'(hi), 64'd5);

        // DIVU 9/2 cancelled in its DONE cycle
        op_code  = 3'd3;
        op_a     = 32'd9;
        op_b     = 32'd2;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 45) begin
            tick();
            n++;
        end
        check("donecancel latency", 64'(n), 64'(33));
        cancel = 1'b1;
        #1;
        check("donecancel done", 64'(done), 64'(1));
        check("donecancel res_lo", 64'(res_lo), 64'd4);
        check("donecancel res_hi", 64'(res_hi), 64'd1);
        tick();
        cancel = 1'b0;
        check("donecancel hi", 64'(hi), 64'd5);
        check("donecancel lo", 64'(lo), 64'h55);

        // DIVU 20/3 with a MULT request held during busy
        op_code  = 3'd3;
        op_a     = 32'd20;
        op_b     = 32'd3;
        op_valid = 1'b1;
        tick();
        op_code = 3'd0;
        op_a    = 32'hFFFFFFFE;
        op_b    = 32'd5;
        n = 1;
        while (done !== 1'b1 && n < 45) begin
            tick();
            n++;
        end
        check("held divu latency", 64'(n), 64'(33));
        check("held divu res_lo", 64'(res_lo), 64'd6);
        check("held divu res_hi", 64'(res_hi), 64'd2);
        tick();
        check("held ready", 64'(op_ready), 64'(1));
        check("held divu hi", 64'(hi), 64'd2);
        check("held divu lo", 64'(lo), 64'd6);
        tick();
        op_valid = 1'b0;
        check("held accepted busy", 64'(busy), 64'(1));
        n = 1;
        while (done !== 1'b1 && n < 45) begin
            tick();
            n++;
        end
        check("held mult latency", 64'(n), 64'(33));
        tick();
        check("held mult hi", 64'(hi), 64'h0FFFFFFFF);
        check("held mult lo", 64'(lo), 64'h0FFFFFFF6);

        // Reserved opcode is a no-op
        op_code  = 3'd6;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        check("reserved busy", 64'(busy), 64'(0));
        check("reserved ready", 64'(op_ready), 64'(1));
        check("reserved hi", 64'(hi), 64'h0FFFFFFFF);

        // Reset in cycle 5 of a DIV
        op_code  = 3'd2;
        op_a     = 32'd100;
        op_b     = 32'hFFFFFFFD;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst mid ready", 64'(op_ready), 64'(1));
        check("rst mid busy", 64'(busy), 64'(0));
        check("rst mid done", 64'(done), 64'(0));
        check("rst mid hi", 64'(hi), 64'(0));
        check("rst mid lo", 64'(lo), 64'(0));

        run_op("mthi", 3'd4, 32'h1234, 32'd0, 1, rh, rl, dbz);
        check("mthi res_lo", 64'(rl), 64'(0));
        check("mthi hi", 64'(hi), 64'h1234);
        check("mthi lo", 64'(lo), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
